// File: rtl/inst_rom_loader_pkg.sv
// Shared definitions for the instruction ROM loader: word/byte types and
// the loader FSM state encodings.
package inst_rom_loader_pkg;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  typedef logic [7:0] ByteBus;

  typedef enum logic [1:0] {
    LdIdle = 2'd0,
    LdLoad = 2'd1,
    LdRun  = 2'd2
  } ld_state_e;

endpackage

// File: rtl/inst_rom_loader_byte_packer.sv
// Big-endian byte-to-word packer for the boot-load port. Emits a write strobe
// on the 4th byte, or on flush with a partial word whose low bytes are zeroed.
module inst_rom_loader_byte_packer
  import inst_rom_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        valid,
  input  ByteBus      data,
  input  logic        flush,
  output logic [31:0] word,
  output logic        wr
);

  logic [1:0]  idx_q;
  logic [31:0] acc_q;
  logic [31:0] acc_nxt;

  // acc_q only ever holds filled byte lanes; unfilled lanes stay zero, which
  // provides the zero padding on flush for free.
  always_comb begin
    acc_nxt = acc_q;
    if (valid) begin
      case (idx_q)
        2'd0:    acc_nxt[31:24] = data;
        2'd1:    acc_nxt[23:16] = data;
        2'd2:    acc_nxt[15:8]  = data;
        default: acc_nxt[7:0]   = data;
      endcase
    end
  end

  assign word = acc_nxt;
  assign wr   = (valid && (idx_q == 2'd3)) || (flush && (valid || (idx_q != 2'd0)));

  always_ff @(posedge clk) begin
    if (!rst || clear || wr) begin
      idx_q <= 2'd0;
      acc_q <= ZeroWord;
    end else if (valid) begin
      idx_q <= idx_q + 2'd1;
      acc_q <= acc_nxt;
    end
  end

endmodule

// File: rtl/inst_rom_loader.sv
// Instruction memory with boot-load port; holds the core in reset until loaded.
// Optional INST_ROM_LOADER_CHECKSUM_EN adds a running sum of written words.
//
// state  | meaning
// LdIdle | after reset, waiting for ld_start or ld_end
// LdLoad | accepting load bytes, core held in reset
// LdRun  | load finished, core released
module inst_rom_loader
  import inst_rom_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic [31:0]           addr,
  output logic [31:0]           inst,
  input  logic                  ld_start,
  input  logic                  ld_valid,
  input  ByteBus                ld_byte,
  input  logic                  ld_end,
  output logic                  ld_ready,
  output logic                  ld_done,
  output logic                  ld_overflow,
  output logic [ADDR_WIDTH:0]   ld_count,
  output logic [31:0]           ld_checksum,
  output logic                  cpu_rst_o
);

  localparam int Depth = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CntZero = '0;
  localparam logic [ADDR_WIDTH:0] CntOne  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [31:0] mem [Depth];

  ld_state_e           state_q, state_nxt;
  logic [ADDR_WIDTH:0] count_q, count_nxt;
  logic                ready_q, overflow_q, cpu_rst_q, done_q;
  logic                in_load, accept, flush, pk_wr;
  logic [31:0]         pk_word;

  // ld_start takes priority over any byte or end request in the same cycle.
  assign in_load = (state_q == LdLoad) && !ld_start;
  assign accept  = in_load && ld_valid && ready_q;
  assign flush   = in_load && ld_end;

  inst_rom_loader_byte_packer u_packer (
    .clk   (clk),
    .rst   (rst),
    .clear (ld_start),
    .valid (accept),
    .data  (ld_byte),
    .flush (flush),
    .word  (pk_word),
    .wr    (pk_wr)
  );

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      LdIdle: begin
        if (ld_start)    state_nxt = LdLoad;
        else if (ld_end) state_nxt = LdRun;
      end
      LdLoad: begin
        if (ld_start)    state_nxt = LdLoad;
        else if (ld_end) state_nxt = LdRun;
      end
      LdRun: begin
        if (ld_start)    state_nxt = LdLoad;
      end
      default: state_nxt = LdIdle;
    endcase
  end

  always_comb begin
    count_nxt = count_q;
    if (ld_start)   count_nxt = CntZero;
    else if (pk_wr) count_nxt = count_q + CntOne;
  end

  // Status outputs lag the state by one cycle so the core sees a clean edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= LdIdle;
      count_q    <= CntZero;
      ready_q    <= 1'b0;
      overflow_q <= 1'b0;
      cpu_rst_q  <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      count_q   <= count_nxt;
      ready_q   <= (state_q == LdLoad) && (state_nxt == LdLoad) && !count_nxt[ADDR_WIDTH];
      cpu_rst_q <= (state_q != LdRun);
      done_q    <= (state_q == LdRun);
      if (ld_start)
        overflow_q <= 1'b0;
      else if ((state_q == LdLoad) && count_nxt[ADDR_WIDTH])
        overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && pk_wr) mem[count_q[ADDR_WIDTH-1:0]] <= pk_word;
  end

`ifdef INST_ROM_LOADER_CHECKSUM_EN
  logic [31:0] checksum_q;

  always_ff @(posedge clk) begin
    if (!rst || ld_start) checksum_q <= ZeroWord;
    else if (pk_wr)       checksum_q <= checksum_q + pk_word;
  end

  assign ld_checksum = checksum_q;
`else
  assign ld_checksum = ZeroWord;
`endif

  // Upper and byte-offset address bits are ignored, so the memory aliases.
  logic unused_addr;
  assign unused_addr = ^{addr[31:ADDR_WIDTH+2], addr[1:0]};

  assign inst        = ce ? mem[addr[ADDR_WIDTH+1:2]] : ZeroWord;
  assign ld_ready    = ready_q;
  assign ld_done     = done_q;
  assign ld_overflow = overflow_q;
  assign ld_count    = count_q;
  assign cpu_rst_o   = cpu_rst_q;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Randomized bench for inst_rom_loader against a queue-based load model.
module tb_inst_rom_loader;
  localparam int AW    = 2;
  localparam int DEPTH = 4;
`ifdef INST_ROM_LOADER_CHECKSUM_EN
  localparam logic [31:0] CKS_WRAP = 32'h0000_0001;
`else
  localparam logic [31:0] CKS_WRAP = 32'h0000_0000;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ce = 1'b0;
  logic [31:0]   addr = '0;
  logic [31:0]   inst;
  logic          ld_start = 1'b0;
  logic          ld_valid = 1'b0;
  logic [7:0]    ld_byte = '0;
  logic          ld_end = 1'b0;
  logic          ld_ready, ld_done, ld_overflow, cpu_rst_o;
  logic [AW:0]   ld_count;
  logic [31:0]   ld_checksum;

  always #5 clk = ~clk;

  inst_rom_loader #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .ce(ce), .addr(addr), .inst(inst),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_end(ld_end),
    .ld_ready(ld_ready), .ld_done(ld_done), .ld_overflow(ld_overflow),
    .ld_count(ld_count), .ld_checksum(ld_checksum), .cpu_rst_o(cpu_rst_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_mem [DEPTH];
  bit          m_written [DEPTH];
  int          m_count;
  logic [31:0] m_sum;
  logic [7:0]  m_part [$];
  bit          m_ovf;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] exp_cksum();
`ifdef INST_ROM_LOADER_CHECKSUM_EN
    return m_sum;
`else
    return 32'h0;
`endif
  endfunction

  task automatic model_write(input logic [31:0] w);
    m_mem[m_count]     = w;
    m_written[m_count] = 1'b1;
    m_count++;
    m_sum = m_sum + w;
    if (m_count == DEPTH) m_ovf = 1'b1;
  endtask

  task automatic model_flush();
    logic [31:0] w;
    if (m_part.size() > 0) begin
      w = 32'h0;
      foreach (m_part[i]) w[31-8*i -: 8] = m_part[i];
      model_write(w);
      m_part.delete();
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    m_part.push_back(b);
    if (m_part.size() == 4) model_flush();
  endtask

  task automatic do_start();
    ld_start = 1'b1;
    cyc();
    ld_start = 1'b0;
    m_count = 0;
    m_sum = 32'h0;
    m_part.delete();
    m_ovf = 1'b0;
    chk("rdy_entry", 32'(ld_ready), 32'd0);
    cyc();
    chk("rdy_load", 32'(ld_ready), 32'd1);
    chk("cpu_held", 32'(cpu_rst_o), 32'd1);
    chk("done_load", 32'(ld_done), 32'd0);
    chk("cnt_clr", 32'(ld_count), 32'd0);
    chk("ovf_clr", 32'(ld_overflow), 32'd0);
    chk("cks_clr", ld_checksum, 32'h0);
  endtask

  task automatic send(input logic [7:0] bytes [$], input bit end_with_last, input bit gaps);
    foreach (bytes[i]) begin
      if (gaps && ($urandom_range(0, 3) == 0)) begin
        ld_valid = 1'b0;
        cyc();
      end
      ld_valid = 1'b1;
      ld_byte  = bytes[i];
      ld_end   = end_with_last && (i == bytes.size() - 1);
      chk("ready", 32'(ld_ready), 32'(m_count < DEPTH));
      if (m_count < DEPTH) model_byte(bytes[i]);
      cyc();
    end
    ld_valid = 1'b0;
    ld_end   = 1'b0;
  endtask

  task automatic finish_load(input bit end_done);
    if (!end_done) begin
      ld_end = 1'b1;
      cyc();
      ld_end = 1'b0;
    end
    model_flush();
    chk("cpu_rst_run0", 32'(cpu_rst_o), 32'd1);
    chk("done_run0", 32'(ld_done), 32'd0);
    cyc();
    chk("cpu_rel", 32'(cpu_rst_o), 32'd0);
    chk("done", 32'(ld_done), 32'd1);
    chk("count", 32'(ld_count), 32'(m_count));
    chk("ovf", 32'(ld_overflow), 32'(m_ovf));
    chk("cksum", ld_checksum, exp_cksum());
  endtask

  task automatic fetch_word(input int idx, input logic [31:0] exp, input string tag);
    logic [31:0] a;
    a = $urandom;
    a[AW+1:2] = idx[AW-1:0];
    ce   = 1'b1;
    addr = a;
    #1 chk(tag, inst, exp);
    ce = 1'b0;
    #1 chk("inst_ce0", inst, 32'h0);
    @(negedge clk);
  endtask

  task automatic fetch_all();
    for (int i = 0; i < DEPTH; i++)
      if (m_written[i]) fetch_word(i, m_mem[i], "inst");
  endtask

  initial begin
    logic [7:0] q [$];
    foreach (m_written[i]) m_written[i] = 1'b0;

    repeat (2) cyc();
    chk("rst_cpu", 32'(cpu_rst_o), 32'd1);
    chk("rst_ready", 32'(ld_ready), 32'd0);
    chk("rst_count", 32'(ld_count), 32'd0);
    chk("rst_done", 32'(ld_done), 32'd0);
    chk("rst_ovf", 32'(ld_overflow), 32'd0);
    chk("rst_cks", ld_checksum, 32'h0);
    rst = 1'b1;
    cyc();
    chk("idle_cpu", 32'(cpu_rst_o), 32'd1);

    // directed two-word load and aliased fetch
    do_start();
    q = '{8'h34, 8'h02, 8'h00, 8'h01, 8'h24, 8'h03, 8'h00, 8'h02};
    send(q, 1'b0, 1'b0);
    finish_load(1'b0);
    chk("count2", 32'(ld_count), 32'd2);
    ce = 1'b1; addr = 32'd4;
    #1 chk("fetch4", inst, 32'h2403_0002);
    addr = 32'd4 + 32'd16 + 32'd3;
    #1 chk("fetch_alias", inst, 32'h2403_0002);
    ce = 1'b0;
    #1 chk("fetch_ce0", inst, 32'h0);
    @(negedge clk);

    // partial word with end on the last byte
    do_start();
    q = '{8'hAA, 8'hBB, 8'hCC};
    send(q, 1'b1, 1'b0);
    finish_load(1'b1);
    chk("partial_cnt", 32'(ld_count), 32'd1);
    fetch_word(0, 32'hAABB_CC00, "partial_word");
    fetch_all();

    // checksum wraps modulo 2^32
    do_start();
    q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h02};
    send(q, 1'b0, 1'b0);
    finish_load(1'b0);
    chk("cksum_wrap", ld_checksum, CKS_WRAP);

    // overflow: 20 bytes into a 4-word memory
    do_start();
    q.delete();
    for (int i = 0; i < 20; i++) q.push_back(8'($urandom));
    send(q, 1'b0, 1'b0);
    chk("ovf_ready", 32'(ld_ready), 32'd0);
    chk("ovf_flag", 32'(ld_overflow), 32'd1);
    chk("ovf_count", 32'(ld_count), 32'd4);
    finish_load(1'b0);
    fetch_word(0, {q[0], q[1], q[2], q[3]}, "ovf_word0");
    fetch_all();

    // randomized loads
    repeat (8) begin
      bit e;
      do_start();
      q.delete();
      for (int i = 0; i < int'($urandom_range(1, 18)); i++) q.push_back(8'($urandom));
      e = 1'($urandom_range(0, 1));
      send(q, e, 1'b1);
      finish_load(e);
      fetch_all();
    end

    // reset in the middle of a load
    do_start();
    q.delete();
    for (int i = 0; i < 6; i++) q.push_back(8'($urandom));
    send(q, 1'b0, 1'b0);
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    m_part.delete();
    m_count = 0;
    m_sum = 32'h0;
    m_ovf = 1'b0;
    chk("mid_cpu", 32'(cpu_rst_o), 32'd1);
    chk("mid_ready", 32'(ld_ready), 32'd0);
    chk("mid_count", 32'(ld_count), 32'd0);
    chk("mid_done", 32'(ld_done), 32'd0);
    ld_end = 1'b1;
    cyc();
    ld_end = 1'b0;
    finish_load(1'b1);
    fetch_word(0, {q[0], q[1], q[2], q[3]}, "mid_word0");
    fetch_all();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/inst_rom_loader.md
# inst_rom_loader

Instruction-memory responder for the core's fetch port. It answers the core's `rom_ce_o`/`rom_addr_o` with `rom_data_i` as a word-addressed instruction memory. It also owns a byte-wide boot-load port that fills that memory, and it holds the core in reset until loading ends. It sits beside the core at top level: its fetch outputs drive the core's fetch inputs, and its `cpu_rst_o` drives the core's `rst`.

## Interface
Parameters:
- `ADDR_WIDTH`, default 10. Word-address width, giving a depth of 2^ADDR_WIDTH words.

Ports (clock and reset first):
- `clk`  in  1  system clock. One clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `ce`  in  1  fetch enable, from the core's `rom_ce_o`.
- `addr`  in  32  fetch byte address, from `rom_addr_o`.
- `inst`  out  32  fetched instruction, to `rom_data_i`.
- `ld_start`  in  1  begin a load: pointer goes to 0 and the core is held in reset.
- `ld_valid`  in  1  `ld_byte` is valid.
- `ld_byte`  in  8  load data byte.
- `ld_end`  in  1  end the load and release the core.
- `ld_ready`  out  1  a byte is accepted when `ld_valid & ld_ready`.
- `ld_done`  out  1  state is RUN.
- `ld_overflow`  out  1  memory filled during a load; sticky until `ld_start`.
- `ld_count`  out  ADDR_WIDTH+1  number of words written in the current load.
- `ld_checksum`  out  32  sum of the words written (see Configuration).
- `cpu_rst_o`  out  1  core reset, active-high; 1 holds the core in reset.

## Operation
- States:
  - IDLE: after reset.
  - LOAD: bytes are being accepted.
  - RUN: the core executes.
- Fetch path is combinational:
  - `inst = ce ? mem[addr[ADDR_WIDTH+1:2]] : 0`.
  - `addr[1:0]` and the upper address bits are ignored, so the memory aliases.
  - Fetch is valid in any state.
- IDLE transitions:
  - `ld_start` → LOAD.
  - `ld_end` → RUN with the existing contents.
  - If both are asserted, `ld_start` wins.
- Entering LOAD:
  - Clears the word pointer, the byte index, `ld_count`, `ld_checksum` and `ld_overflow`.
- Byte packing in LOAD (big-endian):
  - First byte → [31:24], then [23:16], [15:8], [7:0].
  - On the 4th accepted byte, the assembled word is written to `mem[ptr]` at that edge; then the pointer and `ld_count` increment.
- Memory full in LOAD:
  - When `ld_count == 2^ADDR_WIDTH`: `ld_ready` = 0 and `ld_overflow` = 1.
  - Further bytes are dropped; the pointer does not wrap.
- `ld_end` in LOAD:
  - A partial word (byte index ≠ 0) is written with its unfilled low bytes zeroed, and counted.
  - State → RUN.
- `ld_valid & ld_ready & ld_end` in the same cycle: the byte is accepted first, then the end processing applies.
- `ld_start` in LOAD: restarts the load. Memory is not cleared.
- `ld_start` in RUN: → LOAD, and the core is re-held.
- Reset mid-load: returns to IDLE. Words already written remain in memory; any partial word is discarded.

## Timing
Reset values (`rst` = 0 at an edge):
- State IDLE.
- `cpu_rst_o` = 1.
- `ld_ready` = 0, `ld_done` = 0, `ld_overflow` = 0.
- `ld_count` = 0, `ld_checksum` = 0.
- Memory contents are not initialised.

Output timing:
- `ld_ready` is registered: 1 from the cycle after entering LOAD, until full or exit.
- `cpu_rst_o` is registered:
  - Falls the cycle after RUN is entered.
  - Rises the cycle after LOAD is entered.
- `ld_done` goes high together with the `cpu_rst_o` fall.
- `inst` has zero latency from `ce`/`addr`. This matches `pc_reg` → `if_id` fetch: `pc` is presented in one cycle and captured at the next edge.

Write/read timing:
- A memory write is visible to fetch the cycle after it happens.
- The core only fetches once released, so there is no write/read collision.

Throughput: one byte per cycle maximum.

## Configuration
- `INST_ROM_LOADER_CHECKSUM_EN` defined:
  - `ld_checksum` accumulates a 32-bit modulo-2^32 sum of every word written, including a padded final word.
  - It is cleared on LOAD entry.
- Not defined:
  - `ld_checksum` is tied to 0.
  - The adder and its register are absent.

## Structure
- Shared defines file: `ZeroWord`, `ByteBus` (7:0), and the state encodings `LdIdle`/`LdLoad`/`LdRun`.
- Sub-module `byte_packer`:
  - Inputs: byte, valid, flush.
  - Outputs: word plus write strobe.
  - Owns the byte index and the zero-pad logic.
- The FSM, pointer, counters and memory array stay in the top module.

## Test plan
- Reset then idle: hold `rst` = 0 for 2 cycles → `cpu_rst_o` = 1, `ld_ready` = 0, `ld_count` = 0, `ld_done` = 0.
- Full load and fetch:
  - Load bytes 34 02 00 01 then 24 03 00 02, then pulse `ld_end`.
  - Expect `ld_count` = 2, and `cpu_rst_o` = 0 one cycle after RUN.
  - `ce` = 1, `addr` = 4 → `inst` = 0x24030002; `ce` = 0 → `inst` = 0.
- Partial word: load AA BB CC with `ld_end` on the `CC` cycle → `mem[0]` = 0xAABBCC00 and `ld_count` = 1.
- Overflow: with `ADDR_WIDTH` = 2, stream 20 bytes.
  - `ld_ready` drops after byte 16; `ld_overflow` = 1; `ld_count` = 4.
  - `mem[0]` holds bytes 1–4.
- Checksum (macro defined): load 0xFFFFFFFF then 0x00000002 → `ld_checksum` = 0x00000001. Without the macro, `ld_checksum` = 0.
- Reset mid-load: `rst` = 0 after 6 bytes → IDLE, `cpu_rst_o` = 1, `mem[0]` retained, and a subsequent `ld_end` reaches RUN.
